// File: rtl/settle_sampler.sv
// settle_sampler
//   Drives a registered operand pair into an external delayed-gate network,
//   waits SETTLE cycles for the network output to settle, then samples it
//   and offers the result through a valid/ready handshake.
//
//   Optional build macro SETTLE_CHECK_EN: after the wait, the sample is
//   taken into a shadow register and confirmed one cycle later. A mismatch
//   reloads the wait and retries. On the third consecutive mismatch the
//   latest network value is delivered with out_err set.
//
// Ports
//   clk, rst_n          sole clock (rising edge), async active-low reset
//   in_valid/in_ready   operand handshake (ready only in IDLE)
//   in_a, in_b          operands, WIDTH bits each
//   net_a, net_b        registered operands into the network
//   net_res             network result, WIDTH+1 bits, may glitch
//   out_valid/out_ready result handshake
//   out_res, out_err    sampled result and stability-failure flag
//   busy                high whenever the FSM is not in IDLE
//
// state | meaning
// IDLE  | ready for operands
// WAIT  | counting down settle time for the network
// CHECK | confirming the shadow sample (SETTLE_CHECK_EN only)
// DONE  | result held until consumer accepts
module settle_sampler #(
    parameter int WIDTH  = 8,
    parameter int SETTLE = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic [WIDTH-1:0] net_a,
    output logic [WIDTH-1:0] net_b,
    input  logic [WIDTH:0]   net_res,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   out_res,
    output logic             out_err,
    output logic             busy
);

    localparam logic [3:0] LP_RELOAD = 4'(SETTLE - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [3:0]       r_cnt;
    logic [WIDTH-1:0] r_net_a;
    logic [WIDTH-1:0] r_net_b;
    logic [WIDTH:0]   r_out_res;
    logic             r_out_valid;
    logic             r_out_err;

    logic w_accept;
    logic w_dec;
    logic w_sample;
    logic w_release;
`ifdef SETTLE_CHECK_EN
    logic [WIDTH:0] r_shadow;
    logic [1:0]     r_retry;
    logic           w_chk_ok;
    logic           w_retry;
    logic           w_give_up;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_dec       = 1'b0;
        w_sample    = 1'b0;
        w_release   = 1'b0;
`ifdef SETTLE_CHECK_EN
        w_chk_ok    = 1'b0;
        w_retry     = 1'b0;
        w_give_up   = 1'b0;
`endif
        case (r_state)
            ST_IDLE: begin
                if (in_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_sample = 1'b1;
`ifdef SETTLE_CHECK_EN
                    w_state_nxt = ST_CHECK;
`else
                    w_state_nxt = ST_DONE;
`endif
                end else begin
                    w_dec = 1'b1;
                end
            end
`ifdef SETTLE_CHECK_EN
            ST_CHECK: begin
                if (net_res == r_shadow) begin
                    w_chk_ok    = 1'b1;
                    w_state_nxt = ST_DONE;
                end else if (r_retry == 2'd2) begin
                    // third consecutive mismatch: give up and flag it
                    w_give_up   = 1'b1;
                    w_state_nxt = ST_DONE;
                end else begin
                    w_retry     = 1'b1;
                    w_state_nxt = ST_WAIT;
                end
            end
`endif
            ST_DONE: begin
                // out_valid is always high in DONE, so out_ready alone completes
                if (out_ready) begin
                    w_release   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= 4'd0;
            r_net_a     <= '0;
            r_net_b     <= '0;
            r_out_res   <= '0;
            r_out_valid <= 1'b0;
            r_out_err   <= 1'b0;
`ifdef SETTLE_CHECK_EN
            r_shadow    <= '0;
            r_retry     <= 2'd0;
`endif
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_net_a   <= in_a;
                r_net_b   <= in_b;
                r_cnt     <= LP_RELOAD;
                r_out_err <= 1'b0;
`ifdef SETTLE_CHECK_EN
                r_retry   <= 2'd0;
`endif
            end
            if (w_dec) begin
                r_cnt <= r_cnt - 4'd1;
            end
`ifdef SETTLE_CHECK_EN
            if (w_sample) begin
                r_shadow <= net_res;
            end
            if (w_chk_ok) begin
                r_out_res   <= r_shadow;
                r_out_valid <= 1'b1;
            end
            if (w_retry) begin
                r_retry <= r_retry + 2'd1;
                r_cnt   <= LP_RELOAD;
            end
            if (w_give_up) begin
                r_out_res   <= net_res;
                r_out_valid <= 1'b1;
                r_out_err   <= 1'b1;
            end
`else
            if (w_sample) begin
                r_out_res   <= net_res;
                r_out_valid <= 1'b1;
            end
`endif
            if (w_release) begin
                r_out_valid <= 1'b0;
                r_out_err   <= 1'b0;
            end
        end
    end

    assign in_ready  = (r_state == ST_IDLE);
    assign busy      = (r_state != ST_IDLE);
    assign net_a     = r_net_a;
    assign net_b     = r_net_b;
    assign out_res   = r_out_res;
    assign out_valid = r_out_valid;
    assign out_err   = r_out_err;

endmodule

// File: tb/tb_settle_sampler.sv
// Testbench for settle_sampler: two instances (SETTLE=4 and SETTLE=1) with
// an adder network model; expected results queued at accept, checked at output.
module tb_settle_sampler;

    localparam int W  = 8;
    localparam int S0 = 4;
    localparam int S1 = 1;
`ifdef SETTLE_CHECK_EN
    localparam int XTRA = 1;
`else
    localparam int XTRA = 0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic         v0, rdy0, ov0, ordy0, oerr0, busy0;
    logic [W-1:0] a0, b0, na0, nb0;
    logic [W:0]   nr0, ores0;
    logic         v1, rdy1, ov1, ordy1, oerr1, busy1;
    logic [W-1:0] a1, b1, na1, nb1;
    logic [W:0]   nr1, ores1;

    logic glitch_en = 1'b0;
    logic tog = 1'b0;
    always @(posedge clk) tog <= glitch_en ? ~tog : 1'b0;

    assign nr0 = ({1'b0, na0} + {1'b0, nb0}) ^ (tog ? 9'h155 : 9'h000);
    assign nr1 = {1'b0, na1} + {1'b0, nb1};

    settle_sampler #(.WIDTH(W), .SETTLE(S0)) u0 (
        .clk(clk), .rst_n(rst_n), .in_valid(v0), .in_ready(rdy0),
        .in_a(a0), .in_b(b0), .net_a(na0), .net_b(nb0), .net_res(nr0),
        .out_valid(ov0), .out_ready(ordy0), .out_res(ores0),
        .out_err(oerr0), .busy(busy0)
    );

    settle_sampler #(.WIDTH(W), .SETTLE(S1)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(v1), .in_ready(rdy1),
        .in_a(a1), .in_b(b1), .net_a(na1), .net_b(nb1), .net_res(nr1),
        .out_valid(ov1), .out_ready(ordy1), .out_res(ores1),
        .out_err(oerr1), .busy(busy1)
    );

    int vectors = 0;
    int miscompares = 0;
    logic [9:0] exp_q[$];   // {err, res}

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [9:0] pop_exp();
        if (exp_q.size() == 0) return 10'h3FF;
        return exp_q.pop_front();
    endfunction

    task automatic accept0(input logic [W-1:0] a, input logic [W-1:0] b);
        a0 = a; b0 = b; v0 = 1'b1;
        exp_q.push_back({1'b0, 9'(a) + 9'(b)});
        tick();
        v0 = 1'b0;
    endtask

    task automatic wait_out0(output int lat, output bit to);
        lat = 0; to = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            lat++;
            if (ov0) begin to = 1'b0; break; end
        end
    endtask

    task automatic handshake0();
        ordy0 = 1'b1;
        tick();
        ordy0 = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        vectors++; if (rdy0 !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready got %b want 1", rdy0); end
        vectors++; if (busy0 !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", busy0); end
        vectors++; if (ov0 !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got %b want 0", ov0); end
        vectors++; if (na0 !== 8'h00 || nb0 !== 8'h00) begin miscompares++; $display("FAIL reset_net got %h/%h want 00/00", na0, nb0); end
        vectors++; if (ores0 !== 9'h000 || oerr0 !== 1'b0) begin miscompares++; $display("FAIL reset_out got %h/%b want 000/0", ores0, oerr0); end
        tick(); tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        int lat; bit to; logic [9:0] e;
        accept0(8'h7F, 8'h01);
        vectors++; if (busy0 !== 1'b1 || rdy0 !== 1'b0) begin miscompares++; $display("FAIL basic_busy got busy=%b rdy=%b want 1/0", busy0, rdy0); end
        vectors++; if (na0 !== 8'h7F || nb0 !== 8'h01) begin miscompares++; $display("FAIL basic_net got %h/%h want 7f/01", na0, nb0); end
        a0 = 8'hAA; b0 = 8'h55; v0 = 1'b1;   // must be ignored while busy
        wait_out0(lat, to);
        v0 = 1'b0;
        e = pop_exp();
        vectors++; if (to || lat != S0 + XTRA) begin miscompares++; $display("FAIL basic_latency got %0d (timeout=%0b) want %0d", lat, to, S0 + XTRA); end
        vectors++; if (ores0 !== 9'h080 || ores0 !== e[8:0]) begin miscompares++; $display("FAIL basic_res got %h want 080", ores0); end
        vectors++; if (oerr0 !== 1'b0) begin miscompares++; $display("FAIL basic_err got %b want 0", oerr0); end
        vectors++; if (na0 !== 8'h7F || nb0 !== 8'h01) begin miscompares++; $display("FAIL basic_net_hold got %h/%h want 7f/01", na0, nb0); end
        handshake0();
        vectors++; if (ov0 !== 1'b0 || rdy0 !== 1'b1 || na0 !== 8'h7F) begin miscompares++; $display("FAIL basic_idle got ov=%b rdy=%b na=%h want 0/1/7f", ov0, rdy0, na0); end
    endtask

    task automatic test_backpressure();
        int lat; bit to; logic [9:0] e;
        accept0(8'h10, 8'h20);
        wait_out0(lat, to);
        vectors++; if (to || lat != S0 + XTRA) begin miscompares++; $display("FAIL bp_latency got %0d want %0d", lat, S0 + XTRA); end
        e = pop_exp();
        for (int i = 0; i < 6; i++) begin
            a0 = 8'h33; b0 = 8'h44; v0 = 1'b1;
            tick();
            vectors++;
            if (ov0 !== 1'b1 || ores0 !== e[8:0] || rdy0 !== 1'b0 || na0 !== 8'h10) begin
                miscompares++;
                $display("FAIL bp_hold cyc %0d got ov=%b res=%h rdy=%b na=%h want 1/%h/0/10", i, ov0, ores0, rdy0, na0, e[8:0]);
            end
        end
        ordy0 = 1'b1;
        tick();
        ordy0 = 1'b0;
        vectors++; if (ov0 !== 1'b0 || rdy0 !== 1'b1 || na0 !== 8'h10) begin miscompares++; $display("FAIL bp_no_same_edge_accept got ov=%b rdy=%b na=%h want 0/1/10", ov0, rdy0, na0); end
        exp_q.push_back({1'b0, 9'h077});
        tick();
        v0 = 1'b0;
        vectors++; if (busy0 !== 1'b1 || na0 !== 8'h33 || nb0 !== 8'h44) begin miscompares++; $display("FAIL bp_next_accept got busy=%b net=%h/%h want 1/33/44", busy0, na0, nb0); end
        wait_out0(lat, to);
        e = pop_exp();
        vectors++; if (to || ores0 !== e[8:0] || oerr0 !== e[9]) begin miscompares++; $display("FAIL bp_second_res got %h/%b want %h/%b", ores0, oerr0, e[8:0], e[9]); end
        handshake0();
    endtask

    task automatic test_reset_mid();
        int lat; bit to; bit saw; logic [9:0] e;
        accept0(8'h5A, 8'h0F);
        tick(); tick();
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        vectors++; if (ov0 !== 1'b0 || busy0 !== 1'b0 || rdy0 !== 1'b1) begin miscompares++; $display("FAIL rstmid_ctrl got ov=%b busy=%b rdy=%b want 0/0/1", ov0, busy0, rdy0); end
        vectors++; if (na0 !== 8'h00 || nb0 !== 8'h00) begin miscompares++; $display("FAIL rstmid_net got %h/%h want 00/00", na0, nb0); end
        tick(); tick();
        rst_n = 1'b1;
        saw = 1'b0;
        for (int i = 0; i < S0 + XTRA + 3; i++) begin
            tick();
            if (ov0 || busy0) saw = 1'b1;
        end
        vectors++; if (saw) begin miscompares++; $display("FAIL rstmid_no_output got activity=1 want 0"); end
        accept0(8'h80, 8'h80);
        wait_out0(lat, to);
        e = pop_exp();
        vectors++; if (to || lat != S0 + XTRA) begin miscompares++; $display("FAIL rstmid_latency got %0d want %0d", lat, S0 + XTRA); end
        vectors++; if (ores0 !== 9'h100 || ores0 !== e[8:0] || oerr0 !== 1'b0) begin miscompares++; $display("FAIL rstmid_res got %h/%b want 100/0", ores0, oerr0); end
        handshake0();
    endtask

    task automatic test_back_to_back();
        int n_acc; int n_out; int t_out[2]; logic [9:0] e;
        n_acc = 0; n_out = 0; t_out[0] = -1; t_out[1] = -1;
        a1 = 8'hFF; b1 = 8'hFF; v1 = 1'b1; ordy1 = 1'b1;
        for (int c = 0; c < 20 && n_out < 2; c++) begin
            if (v1 && rdy1) begin
                exp_q.push_back({1'b0, 9'(a1) + 9'(b1)});
                n_acc++;
            end
            tick();
            if (n_acc == 1) begin a1 = 8'h00; b1 = 8'h00; end
            if (n_acc == 2) v1 = 1'b0;
            if (ov1) begin
                e = pop_exp();
                t_out[n_out] = c;
                vectors++;
                if (ores1 !== e[8:0] || oerr1 !== e[9]) begin
                    miscompares++;
                    $display("FAIL b2b_res%0d got %h/%b want %h/%b", n_out, ores1, oerr1, e[8:0], e[9]);
                end
                n_out++;
            end
        end
        v1 = 1'b0;
        vectors++; if (n_out != 2) begin miscompares++; $display("FAIL b2b_count got %0d want 2", n_out); end
        vectors++; if (t_out[0] != 1 + XTRA) begin miscompares++; $display("FAIL b2b_first_cycle got %0d want %0d", t_out[0], 1 + XTRA); end
        vectors++; if (t_out[1] - t_out[0] != 3 + XTRA) begin miscompares++; $display("FAIL b2b_period got %0d want %0d", t_out[1] - t_out[0], 3 + XTRA); end
        tick();
    endtask

    task automatic test_random();
        int lat; bit to; logic [9:0] e; logic [7:0] ra, rb;
        for (int i = 0; i < 6; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            accept0(ra, rb);
            wait_out0(lat, to);
            e = pop_exp();
            vectors++;
            if (to || lat != S0 + XTRA || ores0 !== e[8:0] || oerr0 !== e[9]) begin
                miscompares++;
                $display("FAIL rand%0d a=%h b=%h got %h/%b lat %0d want %h/%b lat %0d", i, ra, rb, ores0, oerr0, lat, e[8:0], e[9], S0 + XTRA);
            end
            handshake0();
        end
    endtask

`ifdef SETTLE_CHECK_EN
    task automatic test_retry();
        int lat; bit to; logic [9:0] e;
        // network toggles every edge: every confirm misses, give up after three
        glitch_en = 1'b1;
        accept0(8'h12, 8'h34);
        void'(exp_q.pop_back());
        // tog is 1 just before the 15th edge, so the delivered value is the glitched one
        exp_q.push_back({1'b1, 9'h046 ^ 9'h155});
        wait_out0(lat, to);
        e = pop_exp();
        vectors++; if (to || lat != 3 * (S0 + 1)) begin miscompares++; $display("FAIL retry_giveup_latency got %0d want %0d", lat, 3 * (S0 + 1)); end
        vectors++; if (ores0 !== e[8:0] || oerr0 !== e[9]) begin miscompares++; $display("FAIL retry_giveup_res got %h/%b want %h/%b", ores0, oerr0, e[8:0], e[9]); end
        glitch_en = 1'b0;
        handshake0();
        vectors++; if (oerr0 !== 1'b0 || ov0 !== 1'b0) begin miscompares++; $display("FAIL retry_err_clear got err=%b ov=%b want 0/0", oerr0, ov0); end
        tick();
        // glitching only through the first confirm, stable afterwards
        glitch_en = 1'b1;
        accept0(8'h21, 8'h43);
        lat = 0; to = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            lat++;
            if (lat == S0 + 1) glitch_en = 1'b0;
            if (ov0) begin to = 1'b0; break; end
        end
        e = pop_exp();
        vectors++; if (to || lat != 2 * (S0 + 1)) begin miscompares++; $display("FAIL retry_once_latency got %0d want %0d", lat, 2 * (S0 + 1)); end
        vectors++; if (ores0 !== e[8:0] || oerr0 !== 1'b0) begin miscompares++; $display("FAIL retry_once_res got %h/%b want %h/0", ores0, oerr0, e[8:0]); end
        handshake0();
    endtask
`endif

    initial begin
        rst_n = 1'b0;
        v0 = 1'b0; a0 = '0; b0 = '0; ordy0 = 1'b0;
        v1 = 1'b0; a1 = '0; b1 = '0; ordy1 = 1'b0;
        test_reset();
        test_basic();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        test_random();
`ifdef SETTLE_CHECK_EN
        test_retry();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired after %0d vectors", vectors);
        $fatal(1);
    end

endmodule

// File: doc/settle_sampler.md
SETTLE_SAMPLER -- requirements
Module: settle_sampler

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width in bits.
REQ-002 SHALL have parameter SETTLE, default 4, wait cycles for the delayed-gate network to settle; legal range 1..15.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port in_valid  input  1  operand pair offered.
REQ-006 SHALL have port in_ready  output  1  block can accept operands.
REQ-007 SHALL have port in_a, in_b  input  WIDTH each  operands.
REQ-008 SHALL have port net_a, net_b  output  WIDTH each  registered operands driven into the external delayed-gate network.
REQ-009 SHALL have port net_res  input  WIDTH+1  network result, may glitch until settled.
REQ-010 SHALL have port out_valid  output  1  sampled result available.
REQ-011 SHALL have port out_ready  input  1  consumer accepts result.
REQ-012 SHALL have port out_res  output  WIDTH+1  sampled result.
REQ-013 SHALL have port out_err  output  1  result delivered after failed stability checks.
REQ-014 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-015 SHALL implement states IDLE, WAIT, CHECK, DONE; CHECK reachable only with SETTLE_CHECK_EN defined.
REQ-016 in_ready SHALL be 1 exactly when state is IDLE.
REQ-017 Accept SHALL occur on an edge where in_valid && in_ready; at that edge net_a/net_b load in_a/in_b, a 4-bit counter loads SETTLE-1, and the state goes to WAIT.
REQ-018 In WAIT the counter SHALL decrement each edge; at the edge where it is 0, the block samples net_res.
REQ-019 Without SETTLE_CHECK_EN, the sample SHALL load out_res, set out_valid, and the state goes to DONE; out_valid rises exactly SETTLE edges after accept.
REQ-020 In DONE, out_valid and out_res SHALL hold stable until out_valid && out_ready; on that edge out_valid clears and the state goes to IDLE.
REQ-021 No accept SHALL occur on the same edge that completes an output handshake; the earliest next accept is one edge later.
REQ-022 net_a/net_b SHALL hold the last accepted operands in every state until the next accept.
REQ-023 in_valid while not IDLE SHALL be ignored; in_a/in_b changes after accept SHALL NOT affect net_a/net_b.
REQ-024 out_err SHALL be 0 whenever out_valid is 0 and is cleared at every accept.

Reset
REQ-025 rst_n low SHALL immediately force state IDLE, counter 0, retry count 0, net_a=net_b=0, out_res=0, out_valid=0, out_err=0, busy=0, in_ready=1.
REQ-026 Reset asserted mid-WAIT/CHECK/DONE SHALL abort the operation with no output handshake; the first accept after rst_n deasserts behaves as from power-up.

Configuration
REQ-027 Macro SETTLE_CHECK_EN defined: the WAIT-end sample SHALL go to a shadow register with state CHECK; on the next edge, if net_res equals the shadow, out_res=shadow, out_valid=1, DONE (latency SETTLE+1); otherwise the 2-bit retry count increments, the counter reloads SETTLE-1, and the state returns to WAIT.
REQ-028 With SETTLE_CHECK_EN, on the third consecutive mismatch the block SHALL deliver the latest net_res with out_err=1 and go to DONE; the retry count clears at accept.
REQ-029 Without SETTLE_CHECK_EN: no shadow or retry logic; out_err tied 0.

Verification
REQ-030 WIDTH=8, SETTLE=4, net_res=a+b model; accept a=0x7F, b=0x01 -> out_valid 4 edges later (5 with macro), out_res=0x080, out_err=0.
REQ-031 out_ready held 0 for 6 cycles in DONE -> out_res stable, in_ready=0, second in_valid ignored; out_ready=1 -> IDLE, accept possible one edge later.
REQ-032 rst_n pulsed low 2 cycles after accept -> out_valid/busy drop immediately, net_a=0, no output; the next accept yields the correct result.
REQ-033 SETTLE=1, back-to-back ops a=0xFF, b=0xFF then a=0, b=0 with out_ready=1 -> results 0x1FE then 0x000, 3-cycle period without the macro.
REQ-034 Macro on, net_res toggling every cycle -> 3 retries, out_valid with out_err=1; net_res stable after the first retry -> out_err=0, latency 2*(SETTLE+1).
